// File: rtl/dma_csr_pkg.sv
// rtl/dma_csr_pkg.sv - DMA CSR register map, bit positions, response codes and write FSM states
package dma_csr_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_SRC      = 8'h08;
  localparam logic [7:0] OFF_DST      = 8'h0C;
  localparam logic [7:0] OFF_LEN      = 8'h10;
  localparam logic [7:0] OFF_XFER_CNT = 8'h14;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERR    = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

endpackage

// File: rtl/dma_csr.sv
// rtl/dma_csr.sv - AXI4-Lite CSR slave for the DMA engine
// Optional XFER_CNT register at 0x14 enabled by defining DMA_CSR_XFER_CNT_EN.
module dma_csr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic [31:0]           src_addr_o,
  output logic [31:0]           dst_addr_o,
  output logic [31:0]           len_o,
  output logic                  start_o,
  input  logic                  busy_i,
  input  logic                  done_i,
  input  logic                  err_i,
  output logic                  irq_o
);
  import dma_csr_pkg::*;

  wr_state_t   wr_state;
  logic        aw_held, w_held;
  logic [5:0]  aw_off_q;
  logic [31:0] w_data_q;
  logic        irq_en_q, done_q, err_q;
`ifdef DMA_CSR_XFER_CNT_EN
  logic [31:0] xfer_cnt_q;
`endif

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [5:0]  wr_off;
  logic [31:0] wr_data;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;
  logic        do_start, sw_done, sw_err, clr_done, clr_err;
  logic        wr_ctrl, wr_src, wr_dst, wr_len, wr_cnt;
  logic        irq_en_nx, done_nx, err_nx;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:8], awaddr[1:0],
                              araddr[ADDR_WIDTH-1:8], araddr[1:0]};

  assign bvalid  = (wr_state == WR_RESP);
  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  // A held beat and a beat handshaking this cycle are equivalent for commit.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_off  = aw_held ? aw_off_q : awaddr[7:2];
  assign wr_data = w_held ? w_data_q : wdata;

  always_comb begin
    wr_resp  = RESP_OKAY;
    do_start = 1'b0;
    sw_done  = 1'b0;
    sw_err   = 1'b0;
    clr_done = 1'b0;
    clr_err  = 1'b0;
    wr_ctrl  = 1'b0;
    wr_src   = 1'b0;
    wr_dst   = 1'b0;
    wr_len   = 1'b0;
    wr_cnt   = 1'b0;
    if (commit) begin
      case ({wr_off, 2'b00})
        OFF_CTRL: begin
          wr_ctrl = 1'b1;
          if (wr_data[CTRL_START]) begin
            if (busy_i) begin
              sw_err  = 1'b1;
              wr_resp = RESP_SLVERR;
            end else if (len_o == 32'd0) begin
              sw_done = 1'b1;
            end else begin
              do_start = 1'b1;
            end
          end
        end
        OFF_STATUS: begin
          clr_done = wr_data[STAT_DONE];
          clr_err  = wr_data[STAT_ERR];
        end
        OFF_SRC: if (busy_i) wr_resp = RESP_SLVERR; else wr_src = 1'b1;
        OFF_DST: if (busy_i) wr_resp = RESP_SLVERR; else wr_dst = 1'b1;
        OFF_LEN: if (busy_i) wr_resp = RESP_SLVERR; else wr_len = 1'b1;
`ifdef DMA_CSR_XFER_CNT_EN
        OFF_XFER_CNT: wr_cnt = 1'b1;
`endif
        default: wr_resp = RESP_SLVERR;
      endcase
    end
  end

  // Hardware set beats a software clear landing in the same cycle.
  assign irq_en_nx = wr_ctrl ? wr_data[CTRL_IRQ_EN] : irq_en_q;
  assign done_nx   = (done_q && !clr_done) || done_i || sw_done;
  assign err_nx    = (err_q && !clr_err) || err_i || sw_err;

  always_comb begin
    rd_data = 32'd0;
    rd_resp = RESP_OKAY;
    case ({araddr[7:2], 2'b00})
      OFF_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en_q;
      OFF_STATUS: begin
        rd_data[STAT_BUSY] = busy_i;
        rd_data[STAT_DONE] = done_q;
        rd_data[STAT_ERR]  = err_q;
      end
      OFF_SRC:    rd_data = src_addr_o;
      OFF_DST:    rd_data = dst_addr_o;
      OFF_LEN:    rd_data = len_o;
`ifdef DMA_CSR_XFER_CNT_EN
      OFF_XFER_CNT: rd_data = xfer_cnt_q;
`endif
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state   <= WR_IDLE;
      bresp      <= RESP_OKAY;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_off_q   <= 6'd0;
      w_data_q   <= 32'd0;
      src_addr_o <= 32'd0;
      dst_addr_o <= 32'd0;
      len_o      <= 32'd0;
      start_o    <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_o      <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
`ifdef DMA_CSR_XFER_CNT_EN
      xfer_cnt_q <= 32'd0;
`endif
    end else begin
      if (wr_state == WR_IDLE) begin
        if (commit) begin
          wr_state <= WR_RESP;
          bresp    <= wr_resp;
        end
      end else if (bready) begin
        wr_state <= WR_IDLE;
      end
      aw_held <= commit ? 1'b0 : (aw_held || aw_hs);
      w_held  <= commit ? 1'b0 : (w_held || w_hs);
      if (aw_hs) aw_off_q <= awaddr[7:2];
      if (w_hs)  w_data_q <= wdata;

      start_o <= do_start;
      if (wr_src) src_addr_o <= wr_data;
      if (wr_dst) dst_addr_o <= wr_data;
      if (wr_len) len_o      <= wr_data;
      irq_en_q <= irq_en_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
      irq_o    <= irq_en_nx && (done_nx || err_nx);

      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_data;
        rresp  <= rd_resp;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
`ifdef DMA_CSR_XFER_CNT_EN
      if (wr_cnt)      xfer_cnt_q <= done_i ? 32'd1 : 32'd0;
      else if (done_i) xfer_cnt_q <= xfer_cnt_q + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_dma_csr.sv
// tb/tb_dma_csr.sv - self-checking bench for dma_csr (vector table plus response scoreboard)
module tb_dma_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [1:0]  bresp, rresp;
  logic [31:0] src_addr_o, dst_addr_o, len_o;
  logic        start_o, busy_i, done_i, err_i, irq_o;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];

`ifdef DMA_CSR_XFER_CNT_EN
  localparam logic [1:0] CNT_RESP = 2'b00;
`else
  localparam logic [1:0] CNT_RESP = 2'b10;
`endif

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          lead;
    logic [1:0]  resp;
  } vec_t;

  vec_t tbl[$];

  dma_csr dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .len_o(len_o),
    .start_o(start_o), .busy_i(busy_i), .done_i(done_i), .err_i(err_i),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start_o) n_start++;
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) check("b_unexpected", 0, 1);
      else check("bresp", bresp, bq.pop_front());
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) check("r_unexpected", 0, 1);
      else begin
        logic [33:0] e;
        e = rq.pop_front();
        check("rdata", rdata, e[31:0]);
        check("rresp", rresp, e[33:32]);
      end
    end
  end

  // aw_lead > 0: AW leads W by that many cycles; < 0: W leads; 0: together.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int aw_lead,
                          input logic [1:0] exp_resp, input int hold, input bit pulse_done,
                          output bit start_seen);
    int  aw_at, w_at, cyc;
    bit  aw_ok, w_ok, aw_f, w_f;
    aw_at = (aw_lead < 0) ? -aw_lead : 0;
    w_at  = (aw_lead > 0) ? aw_lead : 0;
    aw_ok = 0; w_ok = 0; cyc = 0;
    bq.push_back(exp_resp);
    @(posedge clk); #1;
    awaddr = addr; wdata = data; done_i = pulse_done; bready = (hold == 0);
    awvalid = (aw_at == 0);
    wvalid  = (w_at == 0);
    while (!(aw_ok && w_ok) && cyc < 50) begin
      @(negedge clk);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); #1;
      done_i = 1'b0;
      cyc++;
      if (aw_f) begin aw_ok = 1; awvalid = 1'b0; end
      if (w_f)  begin w_ok = 1;  wvalid  = 1'b0; end
      if (!aw_ok && cyc == aw_at) awvalid = 1'b1;
      if (!w_ok && cyc == w_at)   wvalid  = 1'b1;
    end
    if (!(aw_ok && w_ok)) check("aw_w_timeout", 0, 1);
    @(negedge clk);
    check("b_latency", bvalid, 1);
    start_seen = start_o;
    for (int i = 0; i < hold; i++) begin
      check("b_hold", {bvalid, bresp, awready, wready}, {1'b1, exp_resp, 2'b00});
      @(negedge clk);
    end
    if (hold != 0) begin
      @(posedge clk); #1;
      bready = 1'b1;
    end
    cyc = 0;
    while (bvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (bvalid) check("b_timeout", 0, 1);
    check("aw_ready_after_b", awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input bit pulse_done);
    int cyc;
    bit fired;
    fired = 0; cyc = 0;
    rq.push_back({exp_resp, exp_data});
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1; done_i = pulse_done;
    while (!fired && cyc < 50) begin
      @(negedge clk);
      fired = arready;
      @(posedge clk); #1;
      done_i = 1'b0;
      cyc++;
    end
    arvalid = 1'b0;
    if (!fired) check("ar_timeout", 0, 1);
    @(negedge clk);
    check("r_latency", rvalid, 1);
    cyc = 0;
    while (rvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (rvalid) check("r_timeout", 0, 1);
  endtask

  task automatic pulse_done_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; done_i = 1'b1;
      @(posedge clk); #1; done_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ss;
    int s0;
    rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; wdata = 0; araddr = 0; busy_i = 0; done_i = 0; err_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctl", {bvalid, rvalid, start_o, irq_o, awready, wready, arready}, 7'b0000111);
    check("reset_regs", {src_addr_o, dst_addr_o}, 64'd0);
    check("reset_len_resp", {len_o, bresp, rresp}, 36'd0);

    tbl.push_back('{0, 32'h04,  32'h0,         0,  2'b00});
    tbl.push_back('{1, 32'h08,  32'h1000_0000, 2,  2'b00});
    tbl.push_back('{0, 32'h08,  32'h1000_0000, 0,  2'b00});
    tbl.push_back('{1, 32'h0C,  32'hDEAD_BEEF, -1, 2'b00});
    tbl.push_back('{1, 32'h10,  32'h40,        0,  2'b00});
    tbl.push_back('{0, 32'h0C,  32'hDEAD_BEEF, 0,  2'b00});
    tbl.push_back('{0, 32'h10,  32'h40,        0,  2'b00});
    tbl.push_back('{0, 32'h00,  32'h0,         0,  2'b00});
    tbl.push_back('{1, 32'h00,  32'h2,         1,  2'b00});
    tbl.push_back('{0, 32'h00,  32'h2,         0,  2'b00});
    tbl.push_back('{0, 32'h3C,  32'h0,         0,  2'b10});
    tbl.push_back('{0, 32'h108, 32'h1000_0000, 0,  2'b00});
    tbl.push_back('{0, 32'h14,  32'h0,         0,  CNT_RESP});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].lead, tbl[i].resp, 0, 0, ss);
      else           do_read(tbl[i].addr, tbl[i].data, tbl[i].resp, 0);
    end
    check("src_out", src_addr_o, 32'h1000_0000);
    check("dst_out", dst_addr_o, 32'hDEAD_BEEF);
    check("len_out", len_o, 32'h40);

    // start, completion and interrupt
    s0 = n_start;
    do_write(32'h00, 32'h3, 0, 2'b00, 0, 0, ss);
    check("start_visible", ss, 1);
    check("start_count", n_start - s0, 1);
    busy_i = 1'b1;
    do_read(32'h04, 32'h1, 2'b00, 0);
    @(posedge clk); #1 done_i = 1'b1;
    @(negedge clk); check("irq_before_done", irq_o, 0);
    @(posedge clk); #1 done_i = 1'b0; busy_i = 1'b0;
    @(negedge clk); check("irq_after_done", irq_o, 1);
    do_read(32'h04, 32'h2, 2'b00, 0);
    do_write(32'h04, 32'h2, 0, 2'b00, 0, 0, ss);
    check("irq_cleared", irq_o, 0);
    do_read(32'h04, 32'h0, 2'b00, 0);

    // start and register writes while busy
    busy_i = 1'b1;
    s0 = n_start;
    do_write(32'h00, 32'h1, 0, 2'b10, 0, 0, ss);
    check("busy_start_count", n_start - s0, 0);
    do_read(32'h04, 32'h5, 2'b00, 0);
    do_write(32'h08, 32'h55, 0, 2'b10, 0, 0, ss);
    do_read(32'h08, 32'h1000_0000, 2'b00, 0);
    check("irq_disabled", irq_o, 0);
    busy_i = 1'b0;
    do_write(32'h04, 32'h4, 0, 2'b00, 0, 0, ss);
    do_read(32'h04, 32'h0, 2'b00, 0);

    // zero-length start completes immediately
    do_write(32'h10, 32'h0, 0, 2'b00, 0, 0, ss);
    s0 = n_start;
    do_write(32'h00, 32'h3, 0, 2'b00, 0, 0, ss);
    check("len0_start_count", n_start - s0, 0);
    check("len0_irq", irq_o, 1);
    do_read(32'h04, 32'h2, 2'b00, 0);

    // W1C coincident with done_i keeps DONE set
    do_write(32'h04, 32'h2, 0, 2'b00, 0, 1, ss);
    do_read(32'h04, 32'h2, 2'b00, 0);
    do_write(32'h04, 32'h2, 0, 2'b00, 0, 0, ss);
    check("irq_clear2", irq_o, 0);

    // STATUS read coincident with done_i returns the old value
    do_read(32'h04, 32'h0, 2'b00, 1);
    do_read(32'h04, 32'h2, 2'b00, 0);
    @(posedge clk); #1 err_i = 1'b1;
    @(posedge clk); #1 err_i = 1'b0;
    do_read(32'h04, 32'h6, 2'b00, 0);
    do_write(32'h04, 32'h6, 0, 2'b00, 0, 0, ss);

    // unmapped write with B back-pressure
    do_write(32'h3C, 32'hFFFF_FFFF, 1, 2'b10, 5, 0, ss);
    check("unmapped_regs", {src_addr_o, dst_addr_o}, {32'h1000_0000, 32'hDEAD_BEEF});
    check("unmapped_len", len_o, 32'h0);
    do_read(32'h00, 32'h2, 2'b00, 0);

`ifdef DMA_CSR_XFER_CNT_EN
    do_write(32'h14, 32'h0, 0, 2'b00, 0, 0, ss);
    pulse_done_n(3);
    do_read(32'h14, 32'h3, 2'b00, 0);
    do_write(32'h14, 32'h0, 0, 2'b00, 0, 1, ss);
    do_read(32'h14, 32'h1, 2'b00, 0);
`else
    do_write(32'h14, 32'h0, 0, 2'b10, 0, 0, ss);
    pulse_done_n(1);
    do_read(32'h14, 32'h0, 2'b10, 0);
`endif

    // reset with an AW beat held
    @(posedge clk); #1 awaddr = 32'h08; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk); check("aw_held", awready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_reset", {awready, wready, bvalid, start_o, irq_o}, 5'b11000);
    check("mid_reset_src", src_addr_o, 32'h0);

    check("sb_empty", bq.size() + rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
